// File: rtl/gbvga_pkg.sv
// Shared constants, FSM state type and address helper for the Game Boy LCD capture path.
package gbvga_pkg;

  localparam int H_PIXELS  = 160;
  localparam int V_LINES   = 144;
  localparam int FB_ADDR_W = 15;
  localparam int PIX_W     = 2;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } cap_state_e;

  // Row-major framebuffer address; 15 bits hold 143*160+159 = 23039 without truncation.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ADDR_W-1:0] x,
                                                   input logic [FB_ADDR_W-1:0] y,
                                                   input logic [FB_ADDR_W-1:0] h);
    return y * h + x;
  endfunction

endpackage

// File: rtl/gb_capture_if.sv
// Game Boy LCD inputs and framebuffer write port of gb_capture, grouped as one bus.
interface gb_capture_if;
  import gbvga_pkg::*;

  logic                 gb_clk;
  logic                 gb_hsync;
  logic                 gb_vsync;
  logic [PIX_W-1:0]     gb_data;
  logic [FB_ADDR_W-1:0] wraddress;
  logic [PIX_W-1:0]     wrdata;
  logic                 wren;
  logic                 frame_done;
  logic                 overrun;
  logic [7:0]           frame_count;

  modport master (
    input  gb_clk, gb_hsync, gb_vsync, gb_data,
    output wraddress, wrdata, wren, frame_done, overrun, frame_count
  );

  modport slave (
    output gb_clk, gb_hsync, gb_vsync, gb_data,
    input  wraddress, wrdata, wren, frame_done, overrun, frame_count
  );
endinterface

// File: rtl/gb_sync_edge.sv
// One-bit multi-flop synchronizer with a history flop producing single-clk rise/fall pulses.
module gb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_level;
    end
  end

  assign o_rise = w_level & ~r_hist;
  assign o_fall = ~w_level & r_hist;

endmodule

// File: rtl/gb_capture.sv
// Captures the Game Boy LCD stream into framebuffer writes (y*H_PIXELS+x).
// Optional GB_CAPTURE_STATS_EN: frame counter and short-frame overrun reporting.
module gb_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int H_PIXELS    = gbvga_pkg::H_PIXELS,
  parameter int V_LINES     = gbvga_pkg::V_LINES
) (
  input  logic         clk,
  input  logic         rst,
  gb_capture_if.master bus
);
  import gbvga_pkg::*;

  localparam int X_W = $clog2(H_PIXELS + 1);
  localparam int Y_W = $clog2(V_LINES + 1);
  localparam logic [X_W-1:0]       X_END = X_W'(H_PIXELS);
  localparam logic [Y_W-1:0]       Y_END = Y_W'(V_LINES);
  localparam logic [FB_ADDR_W-1:0] H_FB  = FB_ADDR_W'(H_PIXELS);

  logic w_pix_fall, w_hs_rise, w_vs_rise;
  logic w_unused_pix_rise, w_unused_hs_fall, w_unused_vs_fall;

  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .i_d(bus.gb_clk), .o_rise(w_unused_pix_rise), .o_fall(w_pix_fall));
  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hs (
    .clk(clk), .rst(rst), .i_d(bus.gb_hsync), .o_rise(w_hs_rise), .o_fall(w_unused_hs_fall));
  gb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vs (
    .clk(clk), .rst(rst), .i_d(bus.gb_vsync), .o_rise(w_vs_rise), .o_fall(w_unused_vs_fall));

  // Pixel data travels a delay line as deep as the gb_clk synchronizer so it lines up with the fall pulse.
  logic [PIX_W-1:0] r_data_dly [SYNC_STAGES];

  // NOTE: this is a short delay line, not a RAM, so every stage is reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_data_dly[i] <= '0;
    end else begin
      r_data_dly[0] <= bus.gb_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_dly[i] <= r_data_dly[i-1];
    end
  end

  cap_state_e           r_state, w_state_nxt;
  logic [X_W-1:0]       r_x, w_x_nxt;
  logic [Y_W-1:0]       r_y, w_y_nxt;
  logic                 r_pend, w_pend_nxt;
  logic [FB_ADDR_W-1:0] r_px, w_px_nxt, r_py, w_py_nxt;
  logic [PIX_W-1:0]     r_pdata, w_pdata_nxt;
  logic                 w_done_nxt, w_ovr_nxt;
  logic                 r_wren, r_frame_done, r_overrun;
  logic [FB_ADDR_W-1:0] r_wraddress;
  logic [PIX_W-1:0]     r_wrdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_VSYNC;
    else     r_state <= w_state_nxt;
  end

  // Coincident events resolve as vsync, then pixel, then hsync.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_pend_nxt  = 1'b0;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_pdata_nxt = r_pdata;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_overrun;

    if (w_vs_rise) begin
      if (r_state == ACTIVE && r_y == Y_END) w_done_nxt = 1'b1;
`ifdef GB_CAPTURE_STATS_EN
      if (r_state == ACTIVE && r_y != Y_END) w_ovr_nxt = 1'b1;
`endif
      w_state_nxt = ACTIVE;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end

    if (w_state_nxt == ACTIVE) begin
      if (w_pix_fall) begin
        if (w_x_nxt < X_END && w_y_nxt < Y_END) begin
          w_pend_nxt  = 1'b1;
          w_px_nxt    = FB_ADDR_W'(w_x_nxt);
          w_py_nxt    = FB_ADDR_W'(w_y_nxt);
          w_pdata_nxt = r_data_dly[SYNC_STAGES-1];
          w_x_nxt     = w_x_nxt + X_W'(1);
        end else begin
          w_ovr_nxt = 1'b1;
        end
      end
      if (w_hs_rise) begin
        w_x_nxt = '0;
        if (w_y_nxt < Y_END) w_y_nxt = w_y_nxt + Y_W'(1);
      end
    end
  end

  // The multiply gets its own cycle: coordinates are registered first, the address one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_pend       <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_pdata      <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_wren       <= 1'b0;
      r_wraddress  <= '0;
      r_wrdata     <= '0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_pend       <= w_pend_nxt;
      r_px         <= w_px_nxt;
      r_py         <= w_py_nxt;
      r_pdata      <= w_pdata_nxt;
      r_frame_done <= w_done_nxt;
      r_overrun    <= w_ovr_nxt;
      r_wren       <= r_pend;
      if (r_pend) begin
        r_wraddress <= fb_addr(r_px, r_py, H_FB);
        r_wrdata    <= r_pdata;
      end
    end
  end

  assign bus.wren       = r_wren;
  assign bus.wraddress  = r_wraddress;
  assign bus.wrdata     = r_wrdata;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

`ifdef GB_CAPTURE_STATS_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_frame_count <= '0;
    else if (w_done_nxt) r_frame_count <= r_frame_count + 8'd1;
  end

  assign bus.frame_count = r_frame_count;
`else
  assign bus.frame_count = '0;
`endif

endmodule

// File: tb/tb_gb_capture.sv
// Scoreboard bench for gb_capture: a frame-level model queues expected writes, a monitor checks them.
module tb_gb_capture;

  localparam int SYNC = 2;
  localparam int H    = 160;
  localparam int V    = 144;
`ifdef GB_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  gb_capture_if bus ();

  gb_capture #(.SYNC_STAGES(SYNC), .H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_writes = 0;
  int  n_done = 0;
  int  last_addr = -1;

  // Frame-level reference: position in the frame and what the block should have reported.
  bit  m_active = 1'b0;
  int  m_x = 0, m_y = 0, m_done = 0, m_fc = 0;
  bit  m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_vsync();
    if (m_active) begin
      if (m_y == V) begin
        m_done++;
        if (STATS) m_fc = (m_fc + 1) % 256;
      end else if (STATS) begin
        m_ovr = 1'b1;
      end
    end
    m_active = 1'b1;
    m_x = 0;
    m_y = 0;
  endfunction

  function automatic void m_pixel(input int d);
    wr_t w;
    if (!m_active) return;
    if (m_x < H && m_y < V) begin
      w.addr = 15'(m_y * H + m_x);
      w.data = 2'(d);
      exp_q.push_back(w);
      m_x++;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  function automatic void m_hsync();
    if (!m_active) return;
    m_x = 0;
    if (m_y < V) m_y++;
  endfunction

  // Monitor: every write strobe is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wren) begin
        n_writes++;
        last_addr = int'(bus.wraddress);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d with nothing expected",
                   bus.wraddress, bus.wrdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wraddress), 32'(e.addr));
          check("wr_data", 32'(bus.wrdata), 32'(e.data));
        end
      end
      if (bus.frame_done) n_done++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int d, input int half = 2);
    bus.gb_data = 2'(d);
    bus.gb_clk  = 1'b1;
    cyc(half);
    bus.gb_clk  = 1'b0;
    m_pixel(d);
    cyc(half);
  endtask

  task automatic hsync();
    bus.gb_hsync = 1'b1;
    m_hsync();
    cyc(2);
    bus.gb_hsync = 1'b0;
    cyc(2);
  endtask

  task automatic vsync();
    bus.gb_vsync = 1'b1;
    m_vsync();
    cyc(2);
    bus.gb_vsync = 1'b0;
    cyc(2);
  endtask

  task automatic vsync_pixel(input int d);
    bus.gb_data = 2'(d);
    bus.gb_clk  = 1'b1;
    cyc(2);
    bus.gb_clk   = 1'b0;
    bus.gb_vsync = 1'b1;
    m_vsync();
    m_pixel(d);
    cyc(2);
    bus.gb_vsync = 1'b0;
    cyc(2);
  endtask

  task automatic pixel_hsync(input int d);
    bus.gb_data = 2'(d);
    bus.gb_clk  = 1'b1;
    cyc(2);
    bus.gb_clk   = 1'b0;
    bus.gb_hsync = 1'b1;
    m_pixel(d);
    m_hsync();
    cyc(2);
    bus.gb_hsync = 1'b0;
    cyc(2);
  endtask

  // Bounded wait for the scoreboard to empty, then settle long enough for frame_done to land.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    cyc(SYNC + 4);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_status(input string name);
    check({name, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    check({name, "_frame_count"}, 32'(bus.frame_count), 32'(m_fc));
    check({name, "_frame_done_count"}, 32'(n_done), 32'(m_done));
  endtask

  initial begin
    int wb, db, lat, lines, np;

    bus.gb_clk = 1'b0; bus.gb_hsync = 1'b0; bus.gb_vsync = 1'b0; bus.gb_data = 2'd0;
    rst = 1'b1;
    cyc(3);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_wraddress", 32'(bus.wraddress), 32'd0);
    check("rst_wrdata", 32'(bus.wrdata), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Pixels before the first vsync are dropped; the one coincident with vsync lands at address 0.
    for (int i = 0; i < 5; i++) pixel($urandom_range(0, 3));
    drain("pre_vsync");
    check("pre_vsync_writes", 32'(n_writes), 32'd0);
    vsync_pixel(2);
    for (int i = 1; i < H; i++) pixel(2);
    hsync();
    drain("line0");
    check("line0_writes", 32'(n_writes), 32'(H));
    check("line0_last_addr", 32'(last_addr), 32'(H - 1));

    // Over-long line: two extra pixels are dropped and flag overrun; the next line starts at 2*H.
    for (int i = 0; i < H + 2; i++) pixel($urandom_range(0, 3));
    drain("long_line");
    check("long_line_writes", 32'(n_writes), 32'(2 * H));
    check("long_line_overrun", 32'(bus.overrun), 32'd1);
    hsync();

    // Raw gb_clk fall to wren, counted in clk edges.
    bus.gb_data = 2'd3;
    bus.gb_clk  = 1'b1;
    cyc(2);
    bus.gb_clk = 1'b0;
    m_pixel(3);
    lat = 0;
    while (!bus.wren && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(SYNC + 2));
    cyc(2);
    pixel_hsync(1);
    pixel(2);
    drain("pix_hsync");
    check("pix_hsync_last_addr", 32'(last_addr), 32'(3 * H));

    // Reset mid-frame at line 50, pixel 80: outputs clear asynchronously, capture waits for vsync.
    while (m_y < 50) hsync();
    for (int i = 0; i < 80; i++) pixel($urandom_range(1, 3));
    drain("pre_reset");
    bus.gb_data = 2'd1;
    bus.gb_clk  = 1'b1;
    cyc(2);
    bus.gb_clk = 1'b0;
    cyc(1);
    #3 rst = 1'b1;
    #1;
    check("midrst_wren", 32'(bus.wren), 32'd0);
    check("midrst_wraddress", 32'(bus.wraddress), 32'd0);
    check("midrst_wrdata", 32'(bus.wrdata), 32'd0);
    check("midrst_overrun", 32'(bus.overrun), 32'd0);
    check("midrst_frame_count", 32'(bus.frame_count), 32'd0);
    exp_q.delete();
    m_active = 1'b0; m_x = 0; m_y = 0; m_ovr = 1'b0; m_fc = 0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    wb = n_writes;
    for (int i = 0; i < 6; i++) pixel($urandom_range(0, 3));
    hsync();
    drain("post_reset");
    check("post_reset_writes", 32'(n_writes - wb), 32'd0);

    // Short frame: vsync after 100 lines is not a completed frame.
    vsync();
    for (int l = 0; l < 100; l++) begin
      if (l % 25 == 0) for (int i = 0; i < 4; i++) pixel($urandom_range(0, 3));
      hsync();
    end
    db = n_done;
    vsync();
    drain("short_frame");
    check("short_frame_no_done", 32'(n_done - db), 32'd0);
    check_status("short_frame");

    // Randomised short frames with ragged line lengths and coincident events.
    for (int f = 0; f < 4; f++) begin
      lines = $urandom_range(1, 3);
      if ($urandom_range(0, 1) != 0) vsync_pixel($urandom_range(0, 3));
      else vsync();
      for (int l = 0; l < lines; l++) begin
        np = $urandom_range(150, 163);
        for (int p = 0; p < np; p++) pixel($urandom_range(0, 3), $urandom_range(1, 3));
        if ($urandom_range(0, 1) != 0) pixel_hsync($urandom_range(0, 3));
        else hsync();
      end
      drain("rand_frame");
      check_status("rand_frame");
    end

    // Full frame; the pixel clock runs at clk/2 here to keep the run short.
    vsync();
    wb = n_writes;
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < H; p++) pixel($urandom_range(0, 3), 1);
      hsync();
    end
    drain("full_frame");
    check("full_frame_writes", 32'(n_writes - wb), 32'(H * V));
    check("full_frame_last_addr", 32'(last_addr), 32'(H * V - 1));
    hsync();
    pixel(1);
    drain("beyond_last_line");
    check("beyond_last_line_writes", 32'(n_writes - wb), 32'(H * V));
    check("beyond_last_line_overrun", 32'(bus.overrun), 32'd1);
    db = n_done;
    vsync();
    drain("frame_end");
    check("frame_end_one_done", 32'(n_done - db), 32'd1);
    check_status("frame_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_capture.md
GB_CAPTURE -- requirements
Module: gb_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on every gb_* input.
REQ-002 SHALL have parameter H_PIXELS, default 160, pixels per Game Boy line.
REQ-003 SHALL have parameter V_LINES, default 144, lines per Game Boy frame.
REQ-004 clk  input  1  system clock (PLL output, the same clock as the framebuffer write port).
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 gb_clk  input  1  Game Boy LCD pixel clock, asynchronous; pixel valid on its falling edge.
REQ-007 gb_hsync  input  1  Game Boy line latch, asynchronous; rising edge ends the current line.
REQ-008 gb_vsync  input  1  Game Boy frame start, asynchronous; rising edge starts a frame.
REQ-009 gb_data  input  2  Game Boy pixel shade, asynchronous.
REQ-010 wraddress  output  15  framebuffer write address, y*H_PIXELS+x.
REQ-011 wrdata  output  2  framebuffer write data.
REQ-012 wren  output  1  framebuffer write strobe, one clk wide.
REQ-013 frame_done  output  1  one-cycle pulse when a complete frame has been captured.
REQ-014 overrun  output  1  sticky flag: a pixel or line arrived outside H_PIXELS x V_LINES.
REQ-015 frame_count  output  8  captured-frame counter (see Configuration).

Function
REQ-016 All gb_* inputs SHALL pass through SYNC_STAGES flops, plus one history flop for edge detection; gb_data SHALL be delayed identically to gb_clk.
REQ-017 The FSM SHALL have the states WAIT_VSYNC and ACTIVE and SHALL leave reset in WAIT_VSYNC.
REQ-018 WAIT_VSYNC: on a vsync rising edge -> ACTIVE, x=0, y=0; all pixel and hsync edges are ignored while in this state.
REQ-019 ACTIVE: on a gb_clk falling edge with x<H_PIXELS and y<V_LINES -> wren=1 on the next clk, wraddress=y*H_PIXELS+x, wrdata=gb_data sampled at that edge; then x+1.
REQ-020 Latency from a raw gb_clk falling edge to wren SHALL be SYNC_STAGES+2 clk cycles.
REQ-021 A pixel edge with x>=H_PIXELS or y>=V_LINES SHALL NOT write and SHALL set overrun.
REQ-022 ACTIVE: on an hsync rising edge -> x=0, y=y+1, saturating at V_LINES.
REQ-023 ACTIVE: on a vsync rising edge -> frame_done=1 for one clk if y==V_LINES (the previous frame was complete); then x=0, y=0 and the state stays ACTIVE.
REQ-024 Simultaneous pixel and hsync edges: the pixel SHALL be written at the current (x,y) first, then the line advances.
REQ-025 Simultaneous pixel and vsync edges: the counters SHALL reset first and the pixel SHALL be written at address 0.
REQ-026 Multiplication width: y*H_PIXELS SHALL be computed at 15 bits with no truncation (max 23039).
REQ-027 When wren=0, wraddress and wrdata SHALL hold their last values.
REQ-028 The clk frequency SHALL be at least 4x the gb_clk frequency; this is a documented constraint and is not checked.

Reset
REQ-029 On rst assertion, the block SHALL immediately set: state=WAIT_VSYNC, x=y=0, wren=0, wraddress=0, wrdata=0, frame_done=0, overrun=0, frame_count=0, synchronizers=0.
REQ-030 Reset mid-frame SHALL abandon the frame; capture resumes only after the next vsync rising edge.

Configuration
REQ-031 Macro GB_CAPTURE_STATS_EN defined: frame_count SHALL increment (wrapping 255->0) on every frame_done pulse, and overrun SHALL also be set by a vsync edge when y!=V_LINES (short frame).
REQ-032 Macro GB_CAPTURE_STATS_EN undefined: frame_count SHALL be tied to 0 and short frames SHALL NOT set overrun; the ports are unchanged.

Structure
REQ-033 Package gbvga_pkg SHALL hold H_PIXELS, V_LINES, FB_ADDR_W=15, PIX_W=2 and the FSM state enum type.
REQ-034 Sub-module gb_sync_edge SHALL implement one-bit SYNC_STAGES synchronization plus rise/fall pulses, instantiated once per control input; gb_data SHALL use a plain delay line of matching depth.

Verification
REQ-035 Directed test: reset, vsync, 160 pixels of value 2'b10, hsync -> 160 wren pulses with addresses 0..159, data 2'b10, y=1.
REQ-036 Directed test: full 144-line frame followed by vsync -> exactly 23040 writes, last address 23039, one frame_done pulse, frame_count=1 with stats enabled.
REQ-037 Directed test: 162 pixels on one line -> 160 writes, overrun=1, next line starts at address 160.
REQ-038 Directed test: pixels before the first vsync -> no wren; a pixel coincident with vsync -> written at address 0.
REQ-039 Directed test: rst asserted at line 50, pixel 80 -> all outputs 0 within the same cycle; after release, pixels are ignored until vsync.
REQ-040 Directed test: stats enabled, vsync after 100 lines -> no frame_done, overrun=1, frame_count unchanged; stats disabled -> overrun=0, frame_count=0.
